// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC register, small instruction
// buffer (FIFO of {instr, pc}) and redirect/misaligned-target handling.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall.
//
// Decode handshake: an entry moves to decode in a cycle where id_valid and
// id_ready are both high; id_valid never depends on id_ready, and the head
// entry (id_instr/id_pc/id_pc_plus4) stays stable until that handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(BUF_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [31:0]      buf_instr_d [BUF_DEPTH];
  logic [31:0]      buf_pc_q    [BUF_DEPTH];
  logic [31:0]      buf_pc_d    [BUF_DEPTH];

  logic empty, full, enq, deq;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign deq   = !empty && id_ready;
  assign enq   = (state_q == ST_RUN) && !redirect_valid && (!full || deq);

  // Next-state for FSM, PC, fault target and buffer pointers.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Flush wins over any same-cycle dequeue; no enqueue this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = ST_RUN;
      end else begin
        state_d    = ST_FAULT;
        fault_pc_d = redirect_pc;
      end
    end else begin
      if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        pc_d     = pc_q + 32'd4;
      end
      if (enq && !deq)      count_d = count_q + CNT_ONE;
      else if (!enq && deq) count_d = count_q - CNT_ONE;
    end
  end

  // Buffer storage write: capture the memory word and its PC at the tail.
  always_comb begin
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (enq) begin
      buf_instr_d[wr_ptr_q] = inst_data;
      buf_pc_d[wr_ptr_q]    = pc_q;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer payload; contents are only observed while count_q says valid.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign inst_addr   = pc_q;
  assign id_valid    = !empty;
  assign id_instr    = empty ? 32'd0 : buf_instr_q[rd_ptr_q];
  assign id_pc       = empty ? 32'd0 : buf_pc_q[rd_ptr_q];
  assign id_pc_plus4 = empty ? 32'd0 : (buf_pc_q[rd_ptr_q] + 32'd4);
  assign fetch_fault = (state_q == ST_FAULT);
  assign fault_pc    = fault_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Performance counters: fetched words and full-buffer stall cycles.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (enq) perf_fetched_d = perf_fetched_q + 32'd1;
    if ((state_q == ST_RUN) && !redirect_valid && full && !deq)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit with a
// queue-based reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  // Clock / reset block
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // Instruction memory: 4 KB, word-indexed, combinational read.
  logic [31:0] mem [1024];
  always_comb inst_data = mem[inst_addr[11:2]];

  // Reference model: a queue of fetched {instr, pc} plus pc / fault state.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fault_pc;
  int unsigned m_fetched;
  int unsigned m_stall;

  int checks = 0;
  int errors = 0;

  // Driver: apply inputs for one cycle, advance the model, pass the edge.
  task automatic tick(input logic rst, input logic rv, input logic [31:0] rpc,
                      input logic rdy);
    logic full_now, deq_now, enq_now;
    ent_t e;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
    full_now = (m_q.size() == BUF_DEPTH);
    deq_now  = (m_q.size() != 0) && rdy;
    enq_now  = !m_fault && !rv && (!full_now || deq_now);
    if (rst) begin
      m_q.delete();
      m_pc       = RESET_PC;
      m_fault    = 1'b0;
      m_fault_pc = 32'd0;
      m_fetched  = 0;
      m_stall    = 0;
    end else begin
      if (!m_fault && !rv && full_now && !deq_now) m_stall++;
      if (rv) begin
        m_q.delete();
        if (rpc[1:0] == 2'b00) begin
          m_pc    = rpc;
          m_fault = 1'b0;
        end else begin
          m_fault    = 1'b1;
          m_fault_pc = rpc;
        end
      end else begin
        if (deq_now) void'(m_q.pop_front());
        if (enq_now) begin
          e.instr = mem[m_pc[11:2]];
          e.pc    = m_pc;
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
          m_fetched++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 32'h0000_0042, 1'b1);
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid);
    end
    checks++;
    if (fetch_fault !== 1'b0 || fault_pc !== 32'd0) begin
      errors++; $display("FAIL reset_fault got=%0b/%h exp=0/0", fetch_fault, fault_pc);
    end
    checks++;
    if (inst_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_pc got=%h exp=%h", inst_addr, RESET_PC);
    end
    checks++;
    if (id_instr !== 32'd0 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin
      errors++;
      $display("FAIL reset_id_zero got=%h/%h/%h exp=0/0/0", id_instr, id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_instr !== 32'h0000_0013 ||
        id_pc_plus4 !== 32'd4) begin
      errors++;
      $display("FAIL stream_first got=%0b/%h/%h/%h exp=1/0/00000013/4",
               id_valid, id_pc, id_instr, id_pc_plus4);
    end
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd4 || id_instr !== 32'h0010_0093) begin
      errors++;
      $display("FAIL stream_second got=%0b/%h/%h exp=1/4/00100093", id_valid, id_pc, id_instr);
    end
    exp_pc = 32'd4;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b1);
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== mem[exp_pc[11:2]]) begin
        errors++;
        $display("FAIL stream_rate got=%0b/%h/%h exp=1/%h/%h",
                 id_valid, id_pc, id_instr, exp_pc, mem[exp_pc[11:2]]);
      end
    end
  endtask

  task automatic test_backpressure();
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (inst_addr !== 32'd8 || id_valid !== 1'b1 || id_pc !== 32'd0) begin
      errors++;
      $display("FAIL bp_hold got=%h/%0b/%h exp=8/1/0", inst_addr, id_valid, id_pc);
    end
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (id_pc !== 32'd4 || inst_addr !== 32'd12) begin
      errors++; $display("FAIL bp_drain1 got=%h/%h exp=4/c", id_pc, inst_addr);
    end
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (id_pc !== 32'd8 || id_instr !== mem[2]) begin
      errors++; $display("FAIL bp_drain2 got=%h/%h exp=8/%h", id_pc, id_instr, mem[2]);
    end
  endtask

  task automatic test_redirect();
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    checks++;
    if (id_valid !== 1'b0 || inst_addr !== 32'h40) begin
      errors++; $display("FAIL redir_flush got=%0b/%h exp=0/40", id_valid, inst_addr);
    end
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== mem[16]) begin
      errors++; $display("FAIL redir_target got=%0b/%h/%h exp=1/40/%h",
                         id_valid, id_pc, id_instr, mem[16]);
    end
  endtask

  task automatic test_fault();
    logic [31:0] held;
    held = m_pc;
    tick(1'b0, 1'b1, 32'h0000_0042, 1'b1);
    checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h42 || id_valid !== 1'b0 ||
        inst_addr !== held) begin
      errors++;
      $display("FAIL fault_enter got=%0b/%h/%0b/%h exp=1/42/0/%h",
               fetch_fault, fault_pc, id_valid, inst_addr, held);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'($urandom_range(0, 1)));
      checks++;
      if (inst_addr !== held || id_valid !== 1'b0 || fetch_fault !== 1'b1) begin
        errors++;
        $display("FAIL fault_frozen got=%h/%0b/%0b exp=%h/0/1",
                 inst_addr, id_valid, fetch_fault, held);
      end
    end
    tick(1'b0, 1'b1, 32'h0000_0045, 1'b1);
    checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h45) begin
      errors++; $display("FAIL fault_update got=%0b/%h exp=1/45", fetch_fault, fault_pc);
    end
    tick(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    checks++;
    if (fetch_fault !== 1'b0 || inst_addr !== 32'h80 || id_valid !== 1'b0) begin
      errors++; $display("FAIL fault_exit got=%0b/%h/%0b exp=0/80/0",
                         fetch_fault, inst_addr, id_valid);
    end
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h80) begin
      errors++; $display("FAIL fault_resume got=%0b/%h exp=1/80", id_valid, id_pc);
    end
  endtask

  task automatic test_reset_dominates();
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 32'h0000_0042, 1'b1);
    checks++;
    if (inst_addr !== RESET_PC || id_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL rst_full got=%h/%0b/%0b exp=%h/0/0",
                         inst_addr, id_valid, fetch_fault, RESET_PC);
    end
    tick(1'b0, 1'b1, 32'h0000_0102, 1'b0);
    tick(1'b1, 1'b1, 32'h0000_0043, 1'b0);
    checks++;
    if (inst_addr !== RESET_PC || id_valid !== 1'b0 || fetch_fault !== 1'b0 ||
        fault_pc !== 32'd0) begin
      errors++; $display("FAIL rst_fault got=%h/%0b/%0b/%h exp=%h/0/0/0",
                         inst_addr, id_valid, fetch_fault, fault_pc, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'd0 || inst_addr !== 32'd0) begin
      errors++; $display("FAIL pc_wrap got=%h/%h/%h exp=fffffffc/0/0",
                         id_pc, id_pc_plus4, inst_addr);
    end
  endtask

  task automatic test_random();
    logic        rst, rv, rdy;
    logic [31:0] rpc, e_instr, e_pc, e_p4;
    logic        e_valid;
    int          rpt = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 99) < 8);
      rpc = {20'($urandom), 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 99) < 60);
      tick(rst, rv, rpc, rdy);
      e_valid = (m_q.size() != 0);
      e_instr = e_valid ? m_q[0].instr : 32'd0;
      e_pc    = e_valid ? m_q[0].pc : 32'd0;
      e_p4    = e_valid ? m_q[0].pc + 32'd4 : 32'd0;
      checks++;
      if (inst_addr !== m_pc || id_valid !== e_valid || id_instr !== e_instr ||
          id_pc !== e_pc || id_pc_plus4 !== e_p4 || fetch_fault !== m_fault ||
          fault_pc !== m_fault_pc) begin
        errors++;
        if (rpt < 10) begin
          rpt++;
          $display("FAIL random cyc=%0d got=%h/%0b/%h/%h/%h/%0b/%h exp=%h/%0b/%h/%h/%h/%0b/%h",
                   i, inst_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault,
                   fault_pc, m_pc, e_valid, e_instr, e_pc, e_p4, m_fault, m_fault_pc);
        end
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (perf_fetched !== m_fetched || perf_stall !== m_stall) begin
        errors++;
        if (rpt < 10) begin
          rpt++;
          $display("FAIL random_perf cyc=%0d got=%0d/%0d exp=%0d/%0d",
                   i, perf_fetched, perf_stall, m_fetched, m_stall);
        end
      end
`endif
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    checks++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetched, perf_stall);
    end
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (perf_fetched !== 32'd3 || perf_stall !== 32'd4) begin
      errors++; $display("FAIL perf_counts got=%0d/%0d exp=3/4", perf_fetched, perf_stall);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b0;
    m_pc           = RESET_PC;
    m_fault        = 1'b0;
    m_fault_pc     = 32'd0;
    m_fetched      = 0;
    m_stall        = 0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_reset_dominates();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that feeds the byte-addressed instruction memory and consumes its read data.
- Holds the program counter and drives the memory address; the memory returns the word for that address combinationally in the same cycle.
- Buffers fetched words in a small FIFO with their PCs and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, flushes on redirect, and flags misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction-buffer entries; a power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- inst_addr  output  32  byte address to instruction memory; always equals the current pc.
- inst_data  input  32  instruction word from memory for inst_addr, valid in the same cycle.
- redirect_valid  input  1  taken branch/jump or trap redirect.
- redirect_pc  input  32  redirect target.
- id_ready  input  1  decode accepts the head entry.
- id_valid  output  1  head entry is valid.
- id_instr  output  32  head instruction word.
- id_pc  output  32  head PC.
- id_pc_plus4  output  32  id_pc + 4, mod 2^32.
- fetch_fault  output  1  misaligned redirect target held; fetch halted.
- fault_pc  output  32  the offending target.

Behaviour:
- Reset, synchronous, dominates every other input:
  - pc=RESET_PC, FIFO empty, state=RUN.
  - id_valid=0, fetch_fault=0, fault_pc=0.
  - id_instr, id_pc and id_pc_plus4 read as 0 while the buffer is empty.
- Enqueue condition: enq = (state==RUN) && !redirect_valid && (!full || deq).
- Dequeue condition: deq = id_valid && id_ready.
- On enq, the entry {inst_data, pc} is written at the tail and pc <= pc+4, wrapping mod 2^32 with no error.
- Simultaneous enq and deq with the buffer full is allowed; occupancy is unchanged.
- Buffer full and no deq: pc holds and inst_addr is stable.
- Empty buffer: id_valid=0, and deq is ignored.
- Latency: an instruction at pc P is presented on id_* one cycle after the cycle inst_addr=P, provided the buffer was empty.
- Peak throughput is 1 instruction per cycle.
- Redirect (redirect_valid=1):
  - FIFO is flushed; occupancy becomes 0 at the next edge.
  - No enqueue happens in that cycle.
  - A deq in the same cycle is still a legal handshake, but its entry is discarded by the flush.
  - Target aligned (redirect_pc[1:0]==0): pc <= redirect_pc; state stays or returns to RUN.
  - Target misaligned: state <= FAULT, fault_pc <= redirect_pc, fetch_fault <= 1, pc unchanged.
- States:
  - RUN: normal fetch.
  - FAULT: no enqueue, pc frozen, fetch_fault=1, id_valid=0 (the buffer was flushed).
  - Exit FAULT only through an aligned redirect (→RUN, fetch_fault<=0) or reset.
  - A misaligned redirect while in FAULT updates fault_pc and remains in FAULT.
- pc[1:0] is always 0 when the state is RUN.
- Addresses beyond the memory's 4 KB range are not checked here; the contents returned are undefined.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two 32-bit output ports are added, both cleared by reset and wrapping on overflow:
  - perf_fetched: increments on each enq.
  - perf_stall: increments each cycle with state==RUN, !redirect_valid and full && !deq.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then id_ready=1 and memory words 0x00000013 at 0, 0x00100093 at 4:
  - cycle 1: id_valid=1, id_pc=0, id_instr=0x00000013, id_pc_plus4=4;
  - next cycle: id_pc=4, id_instr=0x00100093; one instruction per cycle thereafter.
- id_ready=0 for 5 cycles starting from pc=0:
  - buffer fills to BUF_DEPTH=2 and inst_addr holds at 8;
  - on id_ready=1, entries PCs 0 and 4 drain in order, then PC 8 follows.
- redirect_valid=1 with redirect_pc=0x40 and 2 entries buffered:
  - next cycle id_valid=0 and inst_addr=0x40;
  - the following cycle id_pc=0x40.
- redirect_pc=0x42:
  - fetch_fault=1, fault_pc=0x42, id_valid=0, and inst_addr frozen for 10 cycles;
  - then redirect_pc=0x80 gives fetch_fault=0 and id_pc=0x80 one cycle later.
- reset asserted with the buffer full and in FAULT:
  - next edge: pc=RESET_PC, id_valid=0, fetch_fault=0.
- With FETCH_PERF_CNT_EN defined, run 3 fetches followed by 4 full-stall cycles:
  - perf_fetched=3+BUF_DEPTH-fill accounting exact;
  - perf_stall=4.
